// File: rtl/ttt_turn_arbiter.sv
// Tic-tac-toe turn arbiter: sole writer of the 3x3 board, alternates player/computer
// handshakes and reports win/draw. Define TTT_TIMEOUT_EN to forfeit idle turns.
module ttt_turn_arbiter #(
    parameter int unsigned FIRST_MOVER    = 0,
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned CNT_W          = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        p_valid,
    input  logic [3:0]  p_pos,
    output logic        p_ready,
    input  logic        c_valid,
    input  logic [3:0]  c_pos,
    output logic        c_ready,
    output logic        move_ok,
    output logic        move_bad,
    output logic        timeout,
    output logic [17:0] board,
    output logic        turn,
    output logic        game_over,
    output logic [1:0]  result
);

    typedef enum logic [2:0] {
        IDLE,
        P_TURN,
        C_TURN,
        CHECK,
        DONE
    } state_t;

    localparam logic FIRST_TURN = (FIRST_MOVER != 0);

    if ((64'd1 << CNT_W) <= 64'(TIMEOUT_CYCLES)) begin : g_cfg_check
        $error("CNT_W is too narrow to hold TIMEOUT_CYCLES");
    end

    state_t      state_q, state_d;
    logic [17:0] board_q, board_d;
    logic        turn_q, turn_d;
    logic [1:0]  result_q, result_d;
    logic [3:0]  count_q, count_d;
    logic        move_ok_q, move_ok_d;
    logic        move_bad_q, move_bad_d;
    logic        game_over_q, game_over_d;
`ifdef TTT_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;
`endif

    logic       act_valid;
    logic [3:0] act_pos;
    logic [1:0] act_mark;
    logic       act_legal;
    logic [1:0] mover_mark;

    function automatic logic [1:0] cell_at(input logic [17:0] b, input logic [3:0] pos);
        cell_at = 2'b00;
        for (int unsigned k = 1; k <= 9; k++) begin
            if (pos == 4'(k)) cell_at = b[2*k-2 +: 2];
        end
    endfunction

    function automatic logic has_line(input logic [17:0] b, input logic [1:0] mark);
        logic [8:0] hit;
        for (int unsigned k = 0; k < 9; k++) begin
            hit[k] = (b[2*k +: 2] == mark);
        end
        has_line = (hit[0] & hit[1] & hit[2]) | (hit[3] & hit[4] & hit[5]) |
                   (hit[6] & hit[7] & hit[8]) | (hit[0] & hit[3] & hit[6]) |
                   (hit[1] & hit[4] & hit[7]) | (hit[2] & hit[5] & hit[8]) |
                   (hit[0] & hit[4] & hit[8]) | (hit[2] & hit[4] & hit[6]);
    endfunction

    // Only the side that owns the turn is ever looked at; the other valid is ignored.
    always_comb begin
        act_valid  = (state_q == P_TURN) ? p_valid : c_valid;
        act_pos    = (state_q == P_TURN) ? p_pos : c_pos;
        act_mark   = (state_q == P_TURN) ? 2'b01 : 2'b10;
        act_legal  = act_valid && (act_pos >= 4'd1) && (act_pos <= 4'd9) &&
                     (cell_at(board_q, act_pos) == 2'b00);
        mover_mark = turn_q ? 2'b10 : 2'b01;
    end

    always_comb begin
        state_d     = state_q;
        board_d     = board_q;
        turn_d      = turn_q;
        result_d    = result_q;
        count_d     = count_q;
        move_ok_d   = 1'b0;
        move_bad_d  = 1'b0;
        game_over_d = game_over_q;
`ifdef TTT_TIMEOUT_EN
        cnt_d       = cnt_q;
        timeout_d   = 1'b0;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    board_d     = '0;
                    count_d     = '0;
                    result_d    = '0;
                    turn_d      = FIRST_TURN;
                    game_over_d = 1'b0;
                    state_d     = FIRST_TURN ? C_TURN : P_TURN;
`ifdef TTT_TIMEOUT_EN
                    cnt_d       = '0;
`endif
                end
            end
            P_TURN, C_TURN: begin
                if (act_legal) begin
                    for (int unsigned k = 1; k <= 9; k++) begin
                        if (act_pos == 4'(k)) board_d[2*k-2 +: 2] = act_mark;
                    end
                    count_d   = count_q + 4'd1;
                    move_ok_d = 1'b1;
                    state_d   = CHECK;
                end else begin
                    move_bad_d = act_valid;
`ifdef TTT_TIMEOUT_EN
                    // A legal fire on the expiry cycle takes priority, hence the else.
                    if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        timeout_d = 1'b1;
                        turn_d    = ~turn_q;
                        state_d   = (state_q == P_TURN) ? C_TURN : P_TURN;
                        cnt_d     = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
`endif
                end
            end
            CHECK: begin
                if (has_line(board_q, mover_mark)) begin
                    result_d    = mover_mark;
                    game_over_d = 1'b1;
                    state_d     = DONE;
                end else if (count_q == 4'd9) begin
                    result_d    = 2'b11;
                    game_over_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    turn_d  = ~turn_q;
                    state_d = turn_q ? P_TURN : C_TURN;
`ifdef TTT_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            board_q     <= '0;
            turn_q      <= FIRST_TURN;
            result_q    <= '0;
            count_q     <= '0;
            move_ok_q   <= 1'b0;
            move_bad_q  <= 1'b0;
            game_over_q <= 1'b0;
`ifdef TTT_TIMEOUT_EN
            cnt_q       <= '0;
            timeout_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            board_q     <= board_d;
            turn_q      <= turn_d;
            result_q    <= result_d;
            count_q     <= count_d;
            move_ok_q   <= move_ok_d;
            move_bad_q  <= move_bad_d;
            game_over_q <= game_over_d;
`ifdef TTT_TIMEOUT_EN
            cnt_q       <= cnt_d;
            timeout_q   <= timeout_d;
`endif
        end
    end

    assign p_ready   = (state_q == P_TURN);
    assign c_ready   = (state_q == C_TURN);
    assign move_ok   = move_ok_q;
    assign move_bad  = move_bad_q;
    assign board     = board_q;
    assign turn      = turn_q;
    assign game_over = game_over_q;
    assign result    = result_q;
`ifdef TTT_TIMEOUT_EN
    assign timeout   = timeout_q;
`else
    assign timeout   = 1'b0;
`endif

endmodule

// File: doc/ttt_turn_arbiter.md
Name: ttt_turn_arbiter

Overview:
Owns the 3x3 game board and shares it between two move sources: human player (mark 01) and computer engine (mark 10). Enforces alternating turns through valid/ready handshakes and rejects illegal moves. Detects a win or draw one cycle after each accepted move. Sits between the input front-ends and the board display/status logic, and is the only writer of board state.

Parameters:
FIRST_MOVER, 0, side that moves first after start: 0 = player, 1 = computer
TIMEOUT_CYCLES, 16, cycles a side may hold its turn without a handshake; used only when TTT_TIMEOUT_EN is defined
CNT_W, 5, width of the turn timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  reset, asynchronous, active-high
start  in  1  begin a new game; honoured only in IDLE or DONE
p_valid  in  1  player move request
p_pos  in  4  player cell, 1..9, row-major
p_ready  out  1  player may move; combinational, high iff state == P_TURN
c_valid  in  1  computer move request
c_pos  in  4  computer cell, 1..9
c_ready  out  1  high iff state == C_TURN
move_ok  out  1  one-cycle pulse: legal move written
move_bad  out  1  one-cycle pulse: illegal move rejected
timeout  out  1  one-cycle pulse: turn forfeited
board  out  18  cell k (1..9) at bits [2k-1:2k-2]; 00 empty, 01 player, 10 computer
turn  out  1  0 = player, 1 = computer
game_over  out  1  high in DONE
result  out  2  00 none, 01 player win, 10 computer win, 11 draw

Behaviour:
- Reset: state IDLE. board = 0, result = 00, turn = FIRST_MOVER, game_over = 0, all pulses 0, move count = 0, timeout counter = 0.
- States: IDLE, P_TURN, C_TURN, CHECK, DONE.
- IDLE, start=1: go to P_TURN if FIRST_MOVER = 0, otherwise C_TURN. Board and count are already clear.
- Handshake fires on valid && ready. Only the side whose ready is high is sampled. The other side's valid is ignored and produces no pulse, even when both valids are high in the same cycle.
- Legal move: pos in 1..9 and the target cell is 00.
  - On the fire edge: write the mover's mark, count += 1, move_ok = 1 for the next cycle, go to CHECK.
- Illegal move: pos = 0, pos > 9, or the target cell is occupied.
  - move_bad = 1 for one cycle. Board is unchanged and the state stays the same.
  - The requester may retry on the next cycle. ready stays high.
- CHECK (exactly 1 cycle): evaluate the 8 lines on the registered board, for the mover's mark only.
  - Line found: result = 01 or 10, go to DONE.
  - Otherwise count == 9: result = 11, go to DONE.
  - Otherwise: toggle turn and go to the other side's TURN state.
- Latency: fire edge to next ready = 2 cycles. Fire edge to game_over = 2 cycles.
- DONE: game_over = 1, both readys low, result held.
  - start=1: clear board, count and result; turn = FIRST_MOVER; enter the first TURN state on the same edge.
- start outside IDLE and DONE is ignored.
- rst asserted mid-game returns everything to reset values immediately; an in-flight handshake is dropped.
- turn is updated only on the CHECK to TURN transition and on start.

Optional Feature:
Macro TTT_TIMEOUT_EN.
- Defined:
  - The counter clears on entry to P_TURN or C_TURN and increments each cycle in that state without a legal fire. An illegal attempt does not clear it.
  - When it reaches TIMEOUT_CYCLES-1 with no legal fire that cycle: pulse timeout for one cycle, toggle turn, go to the other TURN state. Board and count are unchanged.
  - A legal fire on the expiry cycle wins over the timeout.
- Undefined: no counter logic, timeout tied to 0, a turn waits indefinitely.

Test Plan:
1. Player wins the top row. Reset, start; moves P1, C4, P2, C5, P3. Each move gives move_ok. Two cycles after P3 fires: game_over=1, result=01, board[5:0]=010101.
2. Draw. Full game P5, C1, P9, C3, P2, C8, P7, C4, P6. No line formed, count=9 → result=11, game_over=1.
3. Illegal moves. After P5 and C1, the player tries pos 5, then pos 0, then pos 12. Each gives move_bad, board unchanged, p_ready stays 1. Then P2 is accepted.
4. Arbitration. In P_TURN, p_valid=1 and c_valid=1 in the same cycle with c_pos=3. Only the player move is written; cell 3 stays 00; c_ready=0; no move_bad.
5. Reset and restart. rst pulsed after 3 moves → board=0, state IDLE, p_ready=0. After a finished game, start in DONE → board=0, result=00, p_ready=1 on the next cycle.
6. Timeout (TTT_TIMEOUT_EN, TIMEOUT_CYCLES=16). The player idles 16 cycles → timeout pulse, turn=1, c_ready=1, board unchanged. A legal player fire on cycle 15 is accepted with no timeout pulse.
